// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
//   Computes d = x - y - bin (mod 2^WIDTH) with a borrow chain split into
//   STAGE_W-bit chunks, one chunk per pipeline stage (NSTAGES = WIDTH/STAGE_W).
//   Stage k resolves bits [k*STAGE_W +: STAGE_W] using the borrow registered by
//   stage k-1. Every stage register holds the result chunks computed so far, the
//   operand chunks still to be consumed and the borrow out of its chunk.
//   All stages advance together when the output is empty or being taken.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   block accepts operands (combinational, = ~out_valid | out_ready)
//   x, y, bin  minuend, subtrahend, borrow-in
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   d, bout    difference and borrow-out (registered)
//   ovf        signed overflow, only when PIPE_SUB_SIGNED_OVF_EN is defined
//
// Optional feature macro: PIPE_SUB_SIGNED_OVF_EN
module pipelined_subtractor #(
  parameter int WIDTH   = 32,
  parameter int STAGE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
`ifdef PIPE_SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NSTAGES = WIDTH / STAGE_W;

  if ((WIDTH % STAGE_W) != 0) begin : g_bad_cfg
    $error("pipelined_subtractor: WIDTH must be a multiple of STAGE_W");
  end

  // Ripple full-subtractor over one chunk; returns {borrow_out, difference}.
  function automatic logic [STAGE_W:0] sub_chunk(input logic [STAGE_W-1:0] a,
                                                 input logic [STAGE_W-1:0] b,
                                                 input logic               bi);
    logic [STAGE_W-1:0] r;
    logic               c;
    r = '0;
    c = bi;
    for (int i = 0; i < STAGE_W; i++) begin
      r[i] = a[i] ^ b[i] ^ c;
      c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    return {c, r};
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int DW = (k + 1) * STAGE_W;  // result bits known after this stage
    localparam int RW = WIDTH - DW;         // operand bits still pending

    logic               v_src;
    logic               b_src;
    logic [STAGE_W-1:0] x_c;
    logic [STAGE_W-1:0] y_c;
    logic [STAGE_W:0]   res;
    logic [DW-1:0]      d_nxt;
    logic               v_q;
    logic               b_q;
    logic [DW-1:0]      d_q;

    if (k == 0) begin : g_src
      assign v_src = in_valid;
      assign b_src = bin;
      assign x_c   = x[STAGE_W-1:0];
      assign y_c   = y[STAGE_W-1:0];
      assign d_nxt = res[STAGE_W-1:0];
    end else begin : g_src
      assign v_src = g_stage[k-1].v_q;
      assign b_src = g_stage[k-1].b_q;
      assign x_c   = g_stage[k-1].g_ops.x_q[STAGE_W-1:0];
      assign y_c   = g_stage[k-1].g_ops.y_q[STAGE_W-1:0];
      assign d_nxt = {res[STAGE_W-1:0], g_stage[k-1].d_q};
    end

    assign res = sub_chunk(x_c, y_c, b_src);

    // Data only loads with a valid token so inputs are sampled on transfers only.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        b_q <= 1'b0;
        d_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        if (v_src) begin
          b_q <= res[STAGE_W];
          d_q <= d_nxt;
        end
      end
    end

    if (RW > 0) begin : g_ops
      logic [RW-1:0] x_q;
      logic [RW-1:0] y_q;
      logic [RW-1:0] x_nxt;
      logic [RW-1:0] y_nxt;

      if (k == 0) begin : g_first
        assign x_nxt = x[WIDTH-1:STAGE_W];
        assign y_nxt = y[WIDTH-1:STAGE_W];
      end else begin : g_rest
        assign x_nxt = g_stage[k-1].g_ops.x_q[WIDTH-k*STAGE_W-1:STAGE_W];
        assign y_nxt = g_stage[k-1].g_ops.y_q[WIDTH-k*STAGE_W-1:STAGE_W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv && v_src) begin
          x_q <= x_nxt;
          y_q <= y_nxt;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGES-1].v_q;
  assign d         = g_stage[NSTAGES-1].d_q;
  assign bout      = g_stage[NSTAGES-1].b_q;

`ifdef PIPE_SUB_SIGNED_OVF_EN
  // The last stage works on the top chunk, so its chunk MSBs are the word MSBs.
  logic x_msb;
  logic y_msb;
  logic d_msb;
  assign x_msb = g_stage[NSTAGES-1].x_c[STAGE_W-1];
  assign y_msb = g_stage[NSTAGES-1].y_c[STAGE_W-1];
  assign d_msb = g_stage[NSTAGES-1].res[STAGE_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (adv && g_stage[NSTAGES-1].v_src) begin
      ovf <= (x_msb ^ y_msb) & (x_msb ^ d_msb);
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: directed tests on a 32/8 instance plus
// random streams on 32/8, 16/16 and 64/4 instances against an arithmetic
// reference model with a result queue.
module tb_pipelined_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic        a_iv, a_ir, a_ov, a_or, a_bin, a_bout;
  logic [31:0] a_x, a_y, a_d;
  logic        b_iv, b_ir, b_ov, b_or, b_bin, b_bout;
  logic [15:0] b_x, b_y, b_d;
  logic        c_iv, c_ir, c_ov, c_or, c_bin, c_bout;
  logic [63:0] c_x, c_y, c_d;
`ifdef PIPE_SUB_SIGNED_OVF_EN
  logic        a_ovf, b_ovf, c_ovf;
`endif

  pipelined_subtractor #(.WIDTH(32), .STAGE_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .y(a_y),
    .bin(a_bin), .out_valid(a_ov), .out_ready(a_or), .d(a_d),
`ifdef PIPE_SUB_SIGNED_OVF_EN
    .ovf(a_ovf),
`endif
    .bout(a_bout));

  pipelined_subtractor #(.WIDTH(16), .STAGE_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .y(b_y),
    .bin(b_bin), .out_valid(b_ov), .out_ready(b_or), .d(b_d),
`ifdef PIPE_SUB_SIGNED_OVF_EN
    .ovf(b_ovf),
`endif
    .bout(b_bout));

  pipelined_subtractor #(.WIDTH(64), .STAGE_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .x(c_x), .y(c_y),
    .bin(c_bin), .out_valid(c_ov), .out_ready(c_or), .d(c_d),
`ifdef PIPE_SUB_SIGNED_OVF_EN
    .ovf(c_ovf),
`endif
    .bout(c_bout));

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: {bout, d} = {0,x} - {0,y} - bin, truncated to w result bits.
  function automatic logic [64:0] model(input logic [63:0] xv, input logic [63:0] yv,
                                        input logic bv, input int w);
    logic [64:0] e;
    logic [63:0] m;
    m = mask(w);
    e = {1'b0, xv & m} - {1'b0, yv & m} - {64'd0, bv};
    return {e[64], e[63:0] & m};
  endfunction

  task automatic drive(input int which, input logic iv, input logic [63:0] xv,
                       input logic [63:0] yv, input logic bv, input logic orr);
    case (which)
      0: begin a_iv = iv; a_x = xv[31:0]; a_y = yv[31:0]; a_bin = bv; a_or = orr; end
      1: begin b_iv = iv; b_x = xv[15:0]; b_y = yv[15:0]; b_bin = bv; b_or = orr; end
      default: begin c_iv = iv; c_x = xv; c_y = yv; c_bin = bv; c_or = orr; end
    endcase
  endtask

  task automatic sample(input int which, output logic ir, output logic ov,
                        output logic [63:0] dv, output logic bv);
    case (which)
      0: begin ir = a_ir; ov = a_ov; dv = {32'd0, a_d}; bv = a_bout; end
      1: begin ir = b_ir; ov = b_ov; dv = {48'd0, b_d}; bv = b_bout; end
      default: begin ir = c_ir; ov = c_ov; dv = c_d; bv = c_bout; end
    endcase
  endtask

  // One operation through the 32/8 instance with out_ready=1; result is
  // expected exactly 4 cycles after the accept cycle.
  task automatic single_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                           input logic bv, input logic [32:0] exp);
    @(negedge clk);
    drive(0, 1'b1, {32'd0, xv}, {32'd0, yv}, bv, 1'b1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      a_iv = 1'b0;
      #1;
      check({tag, "_early"}, {64'd0, a_ov}, 65'd0);
    end
    @(negedge clk);
    #1;
    check({tag, "_valid"}, {64'd0, a_ov}, 65'd1);
    check({tag, "_result"}, {32'd0, a_bout, a_d}, {32'd0, exp});
  endtask

  task automatic run_random(input int which, input int nops, input int w);
    logic [64:0] q[$];
    logic [64:0] exp;
    logic [63:0] rx, ry, od;
    logic        rb, iv, orr, ir, ov, ob;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((got < nops) && (cyc < 20000)) begin
      @(negedge clk);
      rx  = {$urandom, $urandom} & mask(w);
      ry  = {$urandom, $urandom} & mask(w);
      if ($urandom_range(0, 7) == 0) ry = rx;  // exercise the equal/borrow-in edge
      rb  = 1'($urandom_range(0, 1));
      iv  = (sent < nops) && ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      drive(which, iv, rx, ry, rb, orr);
      #1;
      sample(which, ir, ov, od, ob);
      if (iv && ir) begin
        q.push_back(model(rx, ry, rb, w));
        sent++;
      end
      if (ov && orr) begin
        check($sformatf("rand_w%0d_nonspurious", w), {64'd0, q.size() != 0}, 65'd1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          check($sformatf("rand_w%0d_op%0d", w, got), {ob, od}, exp);
        end
        got++;
      end
      cyc++;
    end
    check($sformatf("rand_w%0d_count", w), 65'(got), 65'(nops));
    check($sformatf("rand_w%0d_drained", w), 65'(q.size()), 65'd0);
    @(negedge clk);
    drive(which, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int acc;
    int outs;
    rst = 1'b1;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {64'd0, a_ov}, 65'd0);
    check("rst_result", {32'd0, a_bout, a_d}, 65'd0);
    check("rst_in_ready", {64'd0, a_ir}, 65'd1);

    // Directed single operations
    single_op("basic", 32'd5, 32'd3, 1'b0, {1'b0, 32'h0000_0002});
    single_op("ripple_bin", 32'd0, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFFF});
    single_op("ripple_xy", 32'h1234_5678, 32'h1234_5679, 1'b0, {1'b1, 32'hFFFF_FFFF});
    single_op("equal_nobin", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, {1'b0, 32'h0000_0000});
    single_op("chunk_cross", 32'h0001_0000, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_FFFF});

    // Back-pressure: 6 back-to-back operands, consumer stalls cycles 5..7
    acc  = 0;
    outs = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      a_iv  = (acc < 6);
      a_x   = 32'(100 + acc);
      a_y   = 32'(acc);
      a_bin = 1'b0;
      a_or  = !((c >= 5) && (c <= 7));
      #1;
      check($sformatf("bp_in_ready_c%0d", c), {64'd0, a_ir},
            ((c >= 5) && (c <= 7)) ? 65'd0 : 65'd1);
      if (a_iv && a_ir) acc++;
      if (a_ov && a_or) begin
        check($sformatf("bp_out%0d", outs), {32'd0, a_bout, a_d}, 65'd100);
        outs++;
      end
    end
    check("bp_out_count", 65'(outs), 65'd6);
    check("bp_accept_count", 65'(acc), 65'd6);

    // Reset mid-flight: ops at cycles 0..2, reset during cycle 2
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 64'(50 + c), 64'd7, 1'b0, 1'b1);
      rst = (c == 2);
    end
    @(negedge clk);
    rst  = 1'b0;
    a_iv = 1'b0;
    #1;
    check("rstmid_in_ready", {64'd0, a_ir}, 65'd1);
    check("rstmid_result", {32'd0, a_bout, a_d}, 65'd0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rstmid_no_valid_%0d", c), {64'd0, a_ov}, 65'd0);
      @(negedge clk);
      #1;
    end

`ifdef PIPE_SUB_SIGNED_OVF_EN
    single_op("ovf_pos", 32'h8000_0000, 32'd1, 1'b0, {1'b0, 32'h7FFF_FFFF});
    check("ovf_pos_flag", {64'd0, a_ovf}, 65'd1);
    single_op("ovf_none", 32'd5, 32'd3, 1'b0, {1'b0, 32'h0000_0002});
    check("ovf_none_flag", {64'd0, a_ovf}, 65'd0);
`endif

    // Random streams with random bubbles and back-pressure
    run_random(0, 300, 32);
    run_random(1, 1000, 16);
    run_random(2, 1000, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
